// File: rtl/xrv_muldiv_ctrl_if.sv
// Signal bundle between EX/writeback, xrv_muldiv_ctrl and the iterative divider core.
// The slave modport is the controller's view; master is the surrounding pipeline/divider.
interface xrv_muldiv_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_funct3;
  logic [31:0] in_rs1;
  logic [31:0] in_rs2;
  logic [4:0]  in_rd;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_rd;
  logic        out_err;
  logic        busy;
  logic        div_valid;
  logic [31:0] div_dividend;
  logic [31:0] div_divisor;
  logic        div_optype;
  logic [31:0] div_result;
  logic        div_result_valid;

  modport slave (
    input  in_valid, in_funct3, in_rs1, in_rs2, in_rd, flush, out_ready,
           div_result, div_result_valid,
    output in_ready, out_valid, out_data, out_rd, out_err, busy,
           div_valid, div_dividend, div_divisor, div_optype
  );

  modport master (
    output in_valid, in_funct3, in_rs1, in_rs2, in_rd, flush, out_ready,
           div_result, div_result_valid,
    input  in_ready, out_valid, out_data, out_rd, out_err, busy,
           div_valid, div_dividend, div_divisor, div_optype
  );
endinterface

// File: rtl/xrv_muldiv_ctrl.sv
// M-extension issue/writeback controller: resolves divide special cases, drives an unsigned
// divider with operand magnitudes and sign-fixes its result. Define XRV_MUL_EN for the multiplier.
module xrv_muldiv_ctrl #(
  parameter int unsigned DIV_TIMEOUT  = 40,
  parameter bit          FAST_SPECIAL = 1'b1
) (
  input logic              clk,
  input logic              rstb,
  xrv_muldiv_ctrl_if.slave bus
);
  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_DIV_WAIT = 3'd1;
  localparam logic [2:0] S_RESP     = 3'd3;
  localparam logic [2:0] S_DRAIN    = 3'd4;
`ifdef XRV_MUL_EN
  localparam logic [2:0] S_MUL_WAIT = 3'd2;
`endif
  localparam int CNT_W = $clog2(DIV_TIMEOUT + 1);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             res_neg_q, res_neg_d;
  logic [31:0]      out_data_q, out_data_d;
  logic [4:0]       out_rd_q, out_rd_d;
  logic             out_err_q, out_err_d;
  logic             div_valid_q, div_valid_d;
  logic [31:0]      div_dividend_q, div_dividend_d;
  logic [31:0]      div_divisor_q, div_divisor_d;
  logic             div_optype_q, div_optype_d;

  logic        accept, op_signed, op_rem, a_neg, b_neg, b_zero, ovf, special, timeout;
  logic [31:0] a_mag, b_mag, spec_res, div_fixed;

  assign accept    = bus.in_valid && (state_q == S_IDLE) && !bus.flush;
  assign op_signed = !bus.in_funct3[0];
  assign op_rem    = bus.in_funct3[1];
  assign a_neg     = op_signed && bus.in_rs1[31];
  assign b_neg     = op_signed && bus.in_rs2[31];
  assign a_mag     = a_neg ? (~bus.in_rs1 + 32'd1) : bus.in_rs1;
  assign b_mag     = b_neg ? (~bus.in_rs2 + 32'd1) : bus.in_rs2;
  assign b_zero    = (bus.in_rs2 == 32'd0);
  assign ovf       = op_signed && (bus.in_rs1 == 32'h8000_0000) && (bus.in_rs2 == 32'hFFFF_FFFF);
  assign special   = FAST_SPECIAL && (b_zero || ovf);
  assign spec_res  = b_zero ? (op_rem ? bus.in_rs1 : 32'hFFFF_FFFF)
                            : (op_rem ? 32'd0 : 32'h8000_0000);
  assign div_fixed = res_neg_q ? (~bus.div_result + 32'd1) : bus.div_result;
  // The strobe and the timeout share a priority slot: a result arriving on the last
  // allowed cycle still wins over the error return.
  assign timeout   = (cnt_q == CNT_W'(DIV_TIMEOUT - 1));

`ifdef XRV_MUL_EN
  logic [32:0] mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic        mul_hi_q, mul_hi_d;
  logic [63:0] mul_prod;

  // Low 64 bits of the 33x33 signed product; sign-extending first makes a plain multiply exact.
  assign mul_prod = {{31{mul_a_q[32]}}, mul_a_q} * {{31{mul_b_q[32]}}, mul_b_q};
`endif

  always_comb begin
    // NOTE: every _d starts from a hold/default value so no branch can infer a latch.
    state_d        = state_q;
    cnt_d          = cnt_q;
    res_neg_d      = res_neg_q;
    out_data_d     = out_data_q;
    out_rd_d       = out_rd_q;
    out_err_d      = out_err_q;
    div_valid_d    = 1'b0;
    div_dividend_d = div_dividend_q;
    div_divisor_d  = div_divisor_q;
    div_optype_d   = div_optype_q;
`ifdef XRV_MUL_EN
    mul_a_d        = mul_a_q;
    mul_b_d        = mul_b_q;
    mul_hi_d       = mul_hi_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          out_rd_d  = bus.in_rd;
          out_err_d = 1'b0;
          cnt_d     = '0;
          if (bus.in_funct3[2]) begin
            if (special) begin
              out_data_d = spec_res;
              state_d    = S_RESP;
            end else begin
              div_dividend_d = a_mag;
              div_divisor_d  = b_mag;
              div_optype_d   = op_rem;
              res_neg_d      = op_rem ? a_neg : (a_neg ^ b_neg);
              div_valid_d    = 1'b1;
              state_d        = S_DIV_WAIT;
            end
          end else begin
`ifdef XRV_MUL_EN
            mul_a_d  = {(bus.in_funct3[1:0] != 2'd3) & bus.in_rs1[31], bus.in_rs1};
            mul_b_d  = {!bus.in_funct3[1] & bus.in_rs2[31], bus.in_rs2};
            mul_hi_d = (bus.in_funct3[1:0] != 2'd0);
            state_d  = S_MUL_WAIT;
`else
            out_data_d = 32'd0;
            out_err_d  = 1'b1;
            state_d    = S_RESP;
`endif
          end
        end
      end
      S_DIV_WAIT: begin
        if (bus.div_result_valid || timeout) begin
          if (!bus.flush) begin
            out_data_d = bus.div_result_valid ? div_fixed : 32'd0;
            out_err_d  = !bus.div_result_valid;
          end
          state_d = bus.flush ? S_IDLE : S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (bus.flush) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (bus.div_result_valid || timeout) state_d = S_IDLE;
        else                                 cnt_d   = cnt_q + 1'b1;
      end
`ifdef XRV_MUL_EN
      S_MUL_WAIT: begin
        if (!bus.flush) out_data_d = mul_hi_q ? mul_prod[63:32] : mul_prod[31:0];
        state_d = bus.flush ? S_IDLE : S_RESP;
      end
`endif
      S_RESP: begin
        if (bus.out_ready || bus.flush) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state is written only with non-blocking assignments.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      res_neg_q      <= 1'b0;
      out_data_q     <= 32'd0;
      out_rd_q       <= 5'd0;
      out_err_q      <= 1'b0;
      div_valid_q    <= 1'b0;
      div_dividend_q <= 32'd0;
      div_divisor_q  <= 32'd0;
      div_optype_q   <= 1'b0;
`ifdef XRV_MUL_EN
      mul_a_q        <= '0;
      mul_b_q        <= '0;
      mul_hi_q       <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      res_neg_q      <= res_neg_d;
      out_data_q     <= out_data_d;
      out_rd_q       <= out_rd_d;
      out_err_q      <= out_err_d;
      div_valid_q    <= div_valid_d;
      div_dividend_q <= div_dividend_d;
      div_divisor_q  <= div_divisor_d;
      div_optype_q   <= div_optype_d;
`ifdef XRV_MUL_EN
      mul_a_q        <= mul_a_d;
      mul_b_q        <= mul_b_d;
      mul_hi_q       <= mul_hi_d;
`endif
    end
  end

  assign bus.in_ready     = (state_q == S_IDLE);
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.out_valid    = (state_q == S_RESP);
  assign bus.out_data     = out_data_q;
  assign bus.out_rd       = out_rd_q;
  assign bus.out_err      = out_err_q;
  assign bus.div_valid    = div_valid_q;
  assign bus.div_dividend = div_dividend_q;
  assign bus.div_divisor  = div_divisor_q;
  assign bus.div_optype   = div_optype_q;
endmodule

// File: tb/tb_xrv_muldiv_ctrl.sv
// Self-checking bench for xrv_muldiv_ctrl: directed corner cases plus randomized ops
// compared against an arithmetic reference model and a behavioural divider.
module tb_xrv_muldiv_ctrl;
  localparam int DIV_TIMEOUT = 40;

  logic clk = 1'b0;
  logic rstb;
  xrv_muldiv_ctrl_if bus ();

  xrv_muldiv_ctrl #(.DIV_TIMEOUT(DIV_TIMEOUT), .FAST_SPECIAL(1'b1)) dut (
    .clk  (clk),
    .rstb (rstb),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          launches = 0;
  int          div_lat  = 2;
  bit          div_respond = 1'b1;
  bit          stray_req   = 1'b0;
  logic [31:0] last_dd, last_ds;
  logic        last_op;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Reference semantics of the RISC-V M ops, computed with plain integer arithmetic.
  function automatic void ref_op(input logic [2:0] f3, input logic [31:0] a, b,
                                 output logic [31:0] d, output logic err);
    int          sa, sb;
    longint      sa64, sb64, ub64, p;
    longint unsigned pu;
    logic        ovf;
    sa   = $signed(a);
    sb   = $signed(b);
    sa64 = longint'(sa);
    sb64 = longint'(sb);
    ub64 = longint'({32'd0, b});
    ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    err  = 1'b0;
    d    = 32'd0;
    case (f3)
      3'd4: d = (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sb);
      3'd5: d = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: d = (b == 0) ? a : ovf ? 32'd0 : 32'(sa % sb);
      3'd7: d = (b == 0) ? a : a % b;
      default: begin
`ifdef XRV_MUL_EN
        case (f3)
          3'd0: begin p = sa64 * sb64; d = p[31:0];  end
          3'd1: begin p = sa64 * sb64; d = p[63:32]; end
          3'd2: begin p = sa64 * ub64; d = p[63:32]; end
          default: begin pu = {32'd0, a} * {32'd0, b}; d = pu[63:32]; end
        endcase
`else
        err = 1'b1;
`endif
      end
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a, b);
    return f3[2] && ((b == 0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // Behavioural divider: answers each launch with the unsigned quotient/remainder after div_lat cycles.
  initial begin
    int          resp_cnt;
    logic [31:0] resp_val;
    resp_cnt = -1;
    resp_val = 32'd0;
    bus.div_result_valid = 1'b0;
    bus.div_result       = 32'd0;
    forever begin
      @(posedge clk);
      #1;
      bus.div_result_valid = 1'b0;
      if (!rstb) resp_cnt = -1;
      if (resp_cnt > 0) resp_cnt--;
      else if (resp_cnt == 0) begin
        bus.div_result_valid = 1'b1;
        bus.div_result       = resp_val;
        resp_cnt             = -1;
      end
      if (stray_req) begin
        bus.div_result_valid = 1'b1;
        bus.div_result       = 32'h5A5A_5A5A;
      end
      if (bus.div_valid) begin
        launches++;
        last_dd  = bus.div_dividend;
        last_ds  = bus.div_divisor;
        last_op  = bus.div_optype;
        resp_val = (bus.div_divisor == 0) ? (bus.div_optype ? bus.div_dividend : 32'hFFFF_FFFF)
                 : (bus.div_optype ? bus.div_dividend % bus.div_divisor
                                   : bus.div_dividend / bus.div_divisor);
        resp_cnt = div_respond ? div_lat : -1;
      end
    end
  end

  // Issues one op, waits (bounded) for the response and checks it; out_ready is held high.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a, b,
                        input logic [4:0] rd, input logic [31:0] exp_d, input logic exp_e,
                        output int lat);
    int          guard, l0;
    logic        sgn, exp_launch;
    logic [31:0] exp_dd, exp_ds;
    guard = 0;
    while (!bus.in_ready && guard < 100) begin tick(); guard++; end
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    l0 = launches;
    bus.in_valid  = 1'b1;
    bus.in_funct3 = f3;
    bus.in_rs1    = a;
    bus.in_rs2    = b;
    bus.in_rd     = rd;
    tick();
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 200) begin tick(); lat++; end
    check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, "_data"}, bus.out_data, exp_d);
    check({tag, "_rd"}, 32'(bus.out_rd), 32'(rd));
    check({tag, "_err"}, 32'(bus.out_err), 32'(exp_e));
    exp_launch = f3[2] && !is_special(f3, a, b);
    check({tag, "_launches"}, 32'(launches - l0), 32'(exp_launch));
    if (exp_launch) begin
      sgn    = !f3[0];
      exp_dd = (sgn && a[31]) ? 32'(-a) : a;
      exp_ds = (sgn && b[31]) ? 32'(-b) : b;
      check({tag, "_dividend"}, last_dd, exp_dd);
      check({tag, "_divisor"}, last_ds, exp_ds);
      check({tag, "_optype"}, 32'(last_op), 32'(f3[1]));
    end
    tick();
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom();
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          lat, l0;
    logic [31:0] ed, held;
    logic        ee, got, saw_ov, saw_rdy;
    logic [2:0]  f3;
    logic [31:0] a, b;
    rstb          = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_funct3 = 3'd0;
    bus.in_rs1    = 32'd0;
    bus.in_rs2    = 32'd0;
    bus.in_rd     = 5'd0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) tick();
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", bus.out_data, 32'd0);
    check("rst_out_rd", 32'(bus.out_rd), 32'd0);
    check("rst_out_err", 32'(bus.out_err), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_div_valid", 32'(bus.div_valid), 32'd0);
    check("rst_div_dividend", bus.div_dividend, 32'd0);
    check("rst_div_divisor", bus.div_divisor, 32'd0);
    check("rst_div_optype", 32'(bus.div_optype), 32'd0);
    rstb = 1'b1;
    tick();

    // Signed divide/remainder of -7 by 2.
    div_lat = 3;
    run_op("div_m7_2", 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd3, 32'hFFFF_FFFD, 1'b0, lat);
    run_op("rem_m7_2", 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd4, 32'hFFFF_FFFF, 1'b0, lat);

    // Divide by zero answered locally one cycle after accept.
    run_op("divu_by0", 3'd5, 32'h1234, 32'd0, 5'd5, 32'hFFFF_FFFF, 1'b0, lat);
    check("divu_by0_lat", 32'(lat), 32'd1);
    run_op("remu_by0", 3'd7, 32'h1234, 32'd0, 5'd6, 32'h1234, 1'b0, lat);
    check("remu_by0_lat", 32'(lat), 32'd1);

    // Signed overflow.
    run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 32'h8000_0000, 1'b0, lat);
    check("div_ovf_lat", 32'(lat), 32'd1);
    run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 32'd0, 1'b0, lat);

    // MULH of the most negative value squared.
`ifdef XRV_MUL_EN
    run_op("mulh_min", 3'd1, 32'h8000_0000, 32'h8000_0000, 5'd9, 32'h4000_0000, 1'b0, lat);
    check("mulh_min_lat", 32'(lat), 32'd2);
`else
    run_op("mulh_min", 3'd1, 32'h8000_0000, 32'h8000_0000, 5'd9, 32'd0, 1'b1, lat);
    check("mulh_min_lat", 32'(lat), 32'd1);
`endif

    // Writeback stalls for 5 cycles while EX keeps requesting.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1; bus.in_funct3 = 3'd5; bus.in_rs1 = 32'h55; bus.in_rs2 = 32'd0; bus.in_rd = 5'd17;
    tick();
    bus.in_funct3 = 3'd7; bus.in_rs1 = 32'h99; bus.in_rd = 5'd18;
    l0 = launches;
    for (int i = 0; i < 5; i++) begin
      check("stall_out_valid", 32'(bus.out_valid), 32'd1);
      check("stall_out_data", bus.out_data, 32'hFFFF_FFFF);
      check("stall_out_rd", 32'(bus.out_rd), 32'd17);
      check("stall_in_ready", 32'(bus.in_ready), 32'd0);
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    check("stall_release_out_valid", 32'(bus.out_valid), 32'd0);
    check("stall_release_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    check("stall_no_reissue_busy", 32'(bus.busy), 32'd0);
    check("stall_no_launch", 32'(launches - l0), 32'd0);

    // Flush 10 cycles after launch: result drained, nothing delivered.
    div_lat = 20;
    bus.in_valid = 1'b1; bus.in_funct3 = 3'd4; bus.in_rs1 = 32'd1000; bus.in_rs2 = 32'd3; bus.in_rd = 5'd1;
    tick();
    bus.in_valid = 1'b0;
    check("flush_div_valid", 32'(bus.div_valid), 32'd1);
    l0 = launches;
    repeat (10) tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    got = 1'b0; saw_ov = 1'b0; saw_rdy = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      saw_ov  |= bus.out_valid;
      saw_rdy |= bus.in_ready;
      got      = bus.div_result_valid;
      tick();
    end
    check("drain_strobe_seen", 32'(got), 32'd1);
    check("drain_no_out_valid", 32'(saw_ov), 32'd0);
    check("drain_in_ready_low", 32'(saw_rdy), 32'd0);
    check("drain_no_relaunch", 32'(launches - l0), 32'd0);
    check("drain_exit_in_ready", 32'(bus.in_ready), 32'd1);
    check("drain_exit_out_valid", 32'(bus.out_valid), 32'd0);

    // Flush while a result waits in RESP.
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_funct3 = 3'd5; bus.in_rs1 = 32'd7; bus.in_rs2 = 32'd0; bus.in_rd = 5'd2;
    tick();
    bus.in_valid = 1'b0;
    check("resp_flush_pre", 32'(bus.out_valid), 32'd1);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    bus.out_ready = 1'b1;
    check("resp_flush_out_valid", 32'(bus.out_valid), 32'd0);
    check("resp_flush_in_ready", 32'(bus.in_ready), 32'd1);

    // Flush in IDLE ignores the concurrent request.
    bus.in_valid = 1'b1; bus.flush = 1'b1; bus.in_funct3 = 3'd5; bus.in_rs2 = 32'd0;
    tick();
    bus.in_valid = 1'b0; bus.flush = 1'b0;
    check("idle_flush_busy", 32'(bus.busy), 32'd0);

    // Divider never answers: error return after the timeout.
    div_respond = 1'b0;
    run_op("timeout", 3'd5, 32'd100, 32'd7, 5'd11, 32'd0, 1'b1, lat);
    check("timeout_lat", 32'(lat >= DIV_TIMEOUT && lat <= DIV_TIMEOUT + 3), 32'd1);
    div_respond = 1'b1;

    // Randomized ops against the reference model.
    for (int n = 0; n < 150; n++) begin
      f3      = 3'($urandom_range(0, 7));
      a       = pick();
      b       = pick();
      div_lat = $urandom_range(0, 15);
      ref_op(f3, a, b, ed, ee);
      run_op("rand", f3, a, b, 5'($urandom()), ed, ee, lat);
      if (!f3[2]) begin
`ifdef XRV_MUL_EN
        check("rand_mul_lat", 32'(lat), 32'd2);
`else
        check("rand_mul_lat", 32'(lat), 32'd1);
`endif
      end else if (is_special(f3, a, b)) begin
        check("rand_special_lat", 32'(lat), 32'd1);
      end
    end

    // Reset in the middle of a divide, then a stray strobe in IDLE.
    div_lat = 10;
    bus.in_valid = 1'b1; bus.in_funct3 = 3'd4; bus.in_rs1 = 32'd50; bus.in_rs2 = 32'd5; bus.in_rd = 5'd9;
    tick();
    bus.in_valid = 1'b0;
    repeat (2) tick();
    held = bus.div_dividend;
    check("midrst_pre_busy", 32'(bus.busy), 32'd1);
    rstb = 1'b0;
    #1;
    check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_div_dividend", bus.div_dividend, 32'd0);
    check("midrst_out_rd", 32'(bus.out_rd), 32'd0);
    tick();
    rstb = 1'b1;
    stray_req = 1'b1;
    tick();
    stray_req = 1'b0;
    saw_ov = 1'b0;
    repeat (3) begin tick(); saw_ov |= bus.out_valid | bus.busy; end
    check("stray_ignored", 32'(saw_ov), 32'd0);
    run_op("post_rst", 3'd5, 32'd50, 32'd5, 5'd12, 32'd10, 1'b0, lat);
    check("post_rst_dividend_changed", 32'(held), 32'd50);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
